// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - sequential AES InvSubBytes engine with a time-shared inverse S-box group
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int GW = 8 * BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8), and maps 0 to 0 without a special case
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128;
    x2   = gf_mul(x, x);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    return gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] y;
    logic [7:0] c;
    c = 8'h05;
    for (int i = 0; i < 8; i++) begin
      y[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ c[i];
    end
    return gf_inv(y);
  endfunction

  logic [1:0]    r_fsm;
  logic [CW-1:0] r_cnt;
  logic [127:0]  r_state;
  logic          r_in_ready;
  logic [GW-1:0] w_grp_in;
  logic [GW-1:0] w_grp_out;

  assign w_grp_in = r_state[127 - GW * int'(r_cnt) -: GW];

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
    assign w_grp_out[GW - 1 - 8 * j -: 8] = inv_sbox(w_grp_in[GW - 1 - 8 * j -: 8]);
  end

  // in_ready is registered so it only rises on the edge after reset release or handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= S_IDLE;
      r_cnt      <= '0;
      r_state    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (r_in_ready && in_valid) begin
            r_state    <= in_state;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_fsm      <= S_RUN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          r_state[127 - GW * int'(r_cnt) -: GW] <= w_grp_out;
          if (r_cnt == CNT_LAST) begin
            r_fsm <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_fsm      <= S_IDLE;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_fsm <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_fsm == S_DONE);
  assign out_state = r_state;
  assign busy      = (r_fsm != S_IDLE);

endmodule
